// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types plus the arbiter state and requester encodings.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;
  typedef logic [15:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } lc3b_arb_state;

  typedef enum logic {
    IMEM,
    DMEM
  } lc3b_arb_req;

  function automatic lc3b_arb_req other_req(input lc3b_arb_req req);
    return (req == IMEM) ? DMEM : IMEM;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational grant decision between the instruction and data requesters.
module arb_pick
  import lc3b_types::*;
#(
  parameter int RR_MODE = 0
) (
  input  logic        imem_valid,
  input  logic        dmem_valid,
  input  lc3b_arb_req last_grant,
  output logic        grant_valid,
  output lc3b_arb_req grant
);

  logic rr_enable;
  assign rr_enable = (RR_MODE != 0);

  always_comb begin
    grant_valid = imem_valid | dmem_valid;
    grant       = DMEM;
    if (imem_valid && dmem_valid) begin
      // On a conflict, round-robin favours whoever did not complete last.
      grant = rr_enable ? other_req(last_grant) : DMEM;
    end else if (imem_valid) begin
      grant = IMEM;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one physical memory port between the fetch (imem) and memory-stage (dmem)
// requesters, one transaction per grant, with back-to-back handoff on completion.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int RR_MODE = 0
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          imem_stb,
  input  logic          imem_cyc,
  input  lc3b_word      imem_address,
  output lc3b_data      imem_rdata,
  output logic          imem_resp,

  input  logic          dmem_stb,
  input  logic          dmem_cyc,
  input  logic          dmem_write,
  input  lc3b_mem_wmask dmem_byte_enable,
  input  lc3b_word      dmem_address,
  input  lc3b_data      dmem_wdata,
  output lc3b_data      dmem_rdata,
  output logic          dmem_resp,

  output logic          pmem_stb,
  output logic          pmem_cyc,
  output logic          pmem_write,
  output lc3b_mem_wmask pmem_byte_enable,
  output lc3b_word      pmem_address,
  output lc3b_data      pmem_wdata,
  input  lc3b_data      pmem_rdata,
  input  logic          pmem_resp,

  output logic          arb_busy
);

  lc3b_arb_state state_reg, state_next;
  lc3b_arb_req   last_grant_reg, last_grant_next;
  logic          mask_i_reg, mask_i_next;
  logic          mask_d_reg, mask_d_next;

  logic          imem_valid, dmem_valid;
  logic          pick_valid;
  lc3b_arb_req   pick;

  // A requester still strobes in the cycle after its resp; the mask hides that.
  assign imem_valid = imem_stb & imem_cyc & ~mask_i_reg;
  assign dmem_valid = dmem_stb & dmem_cyc & ~mask_d_reg;

  arb_pick #(
    .RR_MODE (RR_MODE)
  ) u_pick (
    .imem_valid  (imem_valid),
    .dmem_valid  (dmem_valid),
    .last_grant  (last_grant_reg),
    .grant_valid (pick_valid),
    .grant       (pick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= DMEM;
      mask_i_reg     <= 1'b0;
      mask_d_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      mask_i_reg     <= mask_i_next;
      mask_d_reg     <= mask_d_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    last_grant_next  = last_grant_reg;
    mask_i_next      = 1'b0;
    mask_d_next      = 1'b0;
    pmem_stb         = 1'b0;
    pmem_cyc         = 1'b0;
    pmem_write       = 1'b0;
    pmem_byte_enable = '0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    imem_resp        = 1'b0;
    dmem_resp        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = (pick == IMEM) ? GRANT_I : GRANT_D;
        end
      end

      GRANT_I: begin
        // Instruction side is read-only: write and byte mask stay at 0.
        pmem_stb     = imem_stb & imem_cyc;
        pmem_cyc     = imem_cyc;
        pmem_address = imem_address;
        if (!imem_cyc) begin
          state_next = IDLE;
        end else if (pmem_resp) begin
          imem_resp       = 1'b1;
          last_grant_next = IMEM;
          mask_i_next     = 1'b1;
          state_next      = dmem_valid ? GRANT_D : IDLE;
        end
      end

      GRANT_D: begin
        pmem_stb         = dmem_stb & dmem_cyc;
        pmem_cyc         = dmem_cyc;
        pmem_write       = dmem_write;
        pmem_byte_enable = dmem_byte_enable;
        pmem_address     = dmem_address;
        pmem_wdata       = dmem_wdata;
        if (!dmem_cyc) begin
          state_next = IDLE;
        end else if (pmem_resp) begin
          dmem_resp       = 1'b1;
          last_grant_next = DMEM;
          mask_d_next     = 1'b1;
          state_next      = imem_valid ? GRANT_I : IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign imem_rdata = pmem_rdata;
  assign dmem_rdata = pmem_rdata;
  assign arb_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: both RR_MODE variants share stimulus, one is observed at a time.
module tb_mem_arbiter;
  import lc3b_types::*;

  typedef struct packed {
    logic         is_d;
    logic [127:0] rdata;
  } exp_t;

  localparam logic [127:0] W_LINE = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          imem_stb, imem_cyc;
  logic [15:0]   imem_address;
  logic          dmem_stb, dmem_cyc, dmem_write;
  logic [15:0]   dmem_byte_enable, dmem_address;
  logic [127:0]  dmem_wdata;
  logic [127:0]  pmem_rdata;
  logic          pmem_resp;

  logic          p_stb [2], p_cyc [2], p_write [2], busy [2], i_resp [2], d_resp [2];
  logic [15:0]   p_be [2], p_addr [2];
  logic [127:0]  p_wdata [2], i_rdata [2], d_rdata [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_arbiter #(
      .RR_MODE (gi)
    ) u_dut (
      .clk              (clk),
      .reset            (reset),
      .imem_stb         (imem_stb),
      .imem_cyc         (imem_cyc),
      .imem_address     (imem_address),
      .imem_rdata       (i_rdata[gi]),
      .imem_resp        (i_resp[gi]),
      .dmem_stb         (dmem_stb),
      .dmem_cyc         (dmem_cyc),
      .dmem_write       (dmem_write),
      .dmem_byte_enable (dmem_byte_enable),
      .dmem_address     (dmem_address),
      .dmem_wdata       (dmem_wdata),
      .dmem_rdata       (d_rdata[gi]),
      .dmem_resp        (d_resp[gi]),
      .pmem_stb         (p_stb[gi]),
      .pmem_cyc         (p_cyc[gi]),
      .pmem_write       (p_write[gi]),
      .pmem_byte_enable (p_be[gi]),
      .pmem_address     (p_addr[gi]),
      .pmem_wdata       (p_wdata[gi]),
      .pmem_rdata       (pmem_rdata),
      .pmem_resp        (pmem_resp),
      .arb_busy         (busy[gi])
    );
  end

  int sel;
  logic o_stb, o_cyc, o_write, o_busy, o_imem_resp, o_dmem_resp;
  logic [15:0] o_be, o_address;
  logic [127:0] o_wdata, o_imem_rdata, o_dmem_rdata;
  assign o_stb        = p_stb[sel];
  assign o_cyc        = p_cyc[sel];
  assign o_write      = p_write[sel];
  assign o_busy       = busy[sel];
  assign o_imem_resp  = i_resp[sel];
  assign o_dmem_resp  = d_resp[sel];
  assign o_be         = p_be[sel];
  assign o_address    = p_addr[sel];
  assign o_wdata      = p_wdata[sel];
  assign o_imem_rdata = i_rdata[sel];
  assign o_dmem_rdata = d_rdata[sel];

  function automatic logic [127:0] line_of(input logic [15:0] a);
    return {a, a ^ 16'h5A5A, ~a, a + 16'h0101, 16'hBEEF, a, a ^ 16'hC3C3, 16'h0F0F};
  endfunction

  // Memory model: acks the observed instance mem_lat cycles after its strobe,
  // or in manual mode plays force_resp one cycle late.
  logic mem_manual, force_resp;
  int   mem_lat, mem_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      mem_cnt    <= 0;
    end else if (mem_manual) begin
      pmem_resp <= force_resp;
      mem_cnt   <= 0;
    end else if (pmem_resp) begin
      pmem_resp <= 1'b0;
      mem_cnt   <= 0;
    end else if (o_stb && o_cyc) begin
      if (mem_cnt == mem_lat - 1) begin
        pmem_resp  <= 1'b1;
        pmem_rdata <= line_of(o_address);
      end
      mem_cnt <= mem_cnt + 1;
    end else begin
      mem_cnt <= 0;
    end
  end

  exp_t sb [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [1:0]   got, want;
  logic [127:0] rd, wrd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    imem_stb = 1'b0; imem_cyc = 1'b0;
    dmem_stb = 1'b0; dmem_cyc = 1'b0; dmem_write = 1'b0;
    dmem_byte_enable = '0;
  endtask

  task automatic drive_imem(input logic [15:0] a);
    imem_stb = 1'b1; imem_cyc = 1'b1; imem_address = a;
  endtask

  task automatic drive_dmem(input logic wr, input logic [15:0] be, input logic [15:0] a, input logic [127:0] wd);
    dmem_stb = 1'b1; dmem_cyc = 1'b1; dmem_write = wr;
    dmem_byte_enable = be; dmem_address = a; dmem_wdata = wd;
  endtask

  // Waits (bounded) for the next requester resp and pops the scoreboard entry it should match.
  task automatic next_resp(input string name);
    exp_t e;
    got = 2'b00;
    rd  = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_imem_resp || o_dmem_resp) begin
        got = {o_imem_resp, o_dmem_resp};
        rd  = o_dmem_resp ? o_dmem_rdata : o_imem_rdata;
        break;
      end
    end
    if (sb.size() != 0) begin
      e    = sb.pop_front();
      want = e.is_d ? 2'b01 : 2'b10;
      wrd  = e.rdata;
    end else begin
      want = 2'b11;
      wrd  = '0;
    end
    $display("txn %s: resp(i,d)=%b rdata=%h", name, got, rd);
  endtask

  task automatic do_reset(input int new_sel);
    reset = 1'b1;
    idle_all();
    mem_manual = 1'b0; force_resp = 1'b0; mem_lat = 3;
    repeat (2) @(negedge clk);
    sel = new_sel;
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset(0);
    reset = 1'b1;
    #2;
    n_checks++;
    if ({o_stb, o_cyc, o_write} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {o_stb, o_cyc, o_write});
    else n_pass++;
    n_checks++;
    if ({o_be, o_address, o_wdata} !== '0) $display("FAIL reset_fields: got %h expected 0", {o_be, o_address, o_wdata});
    else n_pass++;
    n_checks++;
    if ({o_imem_resp, o_dmem_resp, o_busy} !== 3'b000) $display("FAIL reset_resp_busy: got %b expected 000", {o_imem_resp, o_dmem_resp, o_busy});
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_imem_read();
    tick();
    drive_imem(16'h1000);
    sb.push_back({1'b0, line_of(16'h1000)});
    @(negedge clk);
    n_checks++;
    if (o_stb !== 1'b0) $display("FAIL imem_latency: pmem_stb got %b expected 0 in request cycle", o_stb);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({o_stb, o_cyc, o_write, o_be, o_address} !== {3'b110, 16'h0000, 16'h1000})
      $display("FAIL imem_grant: got %h expected %h", {o_stb, o_cyc, o_write, o_be, o_address}, {3'b110, 16'h0000, 16'h1000});
    else n_pass++;
    next_resp("imem_read");
    n_checks++;
    if (got !== want || rd !== wrd) $display("FAIL imem_read: got resp=%b rdata=%h expected resp=%b rdata=%h", got, rd, want, wrd);
    else n_pass++;
    tick();
    idle_all();
    @(negedge clk);
    n_checks++;
    if ({o_busy, o_stb} !== 2'b00) $display("FAIL imem_idle_after: busy,stb got %b expected 00", {o_busy, o_stb});
    else n_pass++;
  endtask

  task automatic test_dmem_write();
    tick();
    drive_dmem(1'b1, 16'h0300, 16'h2008, W_LINE);
    sb.push_back({1'b1, line_of(16'h2008)});
    repeat (2) @(negedge clk);
    n_checks++;
    if ({o_stb, o_cyc, o_write, o_be, o_address, o_wdata} !== {3'b111, 16'h0300, 16'h2008, W_LINE})
      $display("FAIL dmem_write_fields: got %h expected %h", {o_stb, o_cyc, o_write, o_be, o_address, o_wdata}, {3'b111, 16'h0300, 16'h2008, W_LINE});
    else n_pass++;
    next_resp("dmem_write");
    n_checks++;
    if (got !== want || rd !== wrd) $display("FAIL dmem_write: got resp=%b rdata=%h expected resp=%b rdata=%h", got, rd, want, wrd);
    else n_pass++;
    tick();
    idle_all();
    @(negedge clk);
    n_checks++;
    if ({o_dmem_resp, o_imem_resp, o_busy} !== 3'b000) $display("FAIL dmem_single_pulse: got %b expected 000", {o_dmem_resp, o_imem_resp, o_busy});
    else n_pass++;
  endtask

  task automatic test_rr0_conflict();
    tick();
    drive_imem(16'h1100);
    drive_dmem(1'b0, 16'h0000, 16'h2200, '0);
    sb.push_back({1'b1, line_of(16'h2200)});
    sb.push_back({1'b0, line_of(16'h1100)});
    repeat (2) @(negedge clk);
    n_checks++;
    if (o_address !== 16'h2200) $display("FAIL rr0_dmem_first: address got %h expected 2200", o_address);
    else n_pass++;
    next_resp("rr0_dmem");
    n_checks++;
    if (got !== want || rd !== wrd) $display("FAIL rr0_dmem: got resp=%b rdata=%h expected resp=%b rdata=%h", got, rd, want, wrd);
    else n_pass++;
    tick();
    dmem_stb = 1'b0; dmem_cyc = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_busy, o_stb, o_address} !== {2'b11, 16'h1100}) $display("FAIL rr0_handoff: got %h expected %h", {o_busy, o_stb, o_address}, {2'b11, 16'h1100});
    else n_pass++;
    next_resp("rr0_imem");
    n_checks++;
    if (got !== want || rd !== wrd) $display("FAIL rr0_imem: got resp=%b rdata=%h expected resp=%b rdata=%h", got, rd, want, wrd);
    else n_pass++;
    tick();
    idle_all();
    @(negedge clk);
  endtask

  task automatic test_mask();
    tick();
    drive_imem(16'h1200);
    sb.push_back({1'b0, line_of(16'h1200)});
    next_resp("mask_first");
    n_checks++;
    if (got !== want || rd !== wrd) $display("FAIL mask_first: got resp=%b rdata=%h expected resp=%b rdata=%h", got, rd, want, wrd);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({o_busy, o_stb} !== 2'b00) $display("FAIL mask_hold_cycle: busy,stb got %b expected 00", {o_busy, o_stb});
    else n_pass++;
    tick();
    idle_all();
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL mask_no_regrant: busy got %b expected 0", o_busy);
    else n_pass++;
    tick();
    drive_imem(16'h1210);
    sb.push_back({1'b0, line_of(16'h1210)});
    repeat (2) @(negedge clk);
    n_checks++;
    if ({o_stb, o_address} !== {1'b1, 16'h1210}) $display("FAIL mask_fresh_grant: got %h expected %h", {o_stb, o_address}, {1'b1, 16'h1210});
    else n_pass++;
    next_resp("mask_fresh");
    n_checks++;
    if (got !== want || rd !== wrd) $display("FAIL mask_fresh: got resp=%b rdata=%h expected resp=%b rdata=%h", got, rd, want, wrd);
    else n_pass++;
    tick();
    idle_all();
    @(negedge clk);
  endtask

  task automatic test_rr1_conflict();
    tick();
    drive_imem(16'h1300);
    drive_dmem(1'b0, 16'h0000, 16'h2300, '0);
    sb.push_back({1'b0, line_of(16'h1300)});
    repeat (2) @(negedge clk);
    n_checks++;
    if ({o_stb, o_address} !== {1'b1, 16'h1300}) $display("FAIL rr1_imem_first: got %h expected %h", {o_stb, o_address}, {1'b1, 16'h1300});
    else n_pass++;
    tick();
    dmem_stb = 1'b0; dmem_cyc = 1'b0;
    next_resp("rr1_imem");
    n_checks++;
    if (got !== want || rd !== wrd) $display("FAIL rr1_imem: got resp=%b rdata=%h expected resp=%b rdata=%h", got, rd, want, wrd);
    else n_pass++;
    tick();
    idle_all();
    repeat (2) @(negedge clk);
    tick();
    drive_imem(16'h1310);
    drive_dmem(1'b0, 16'h0000, 16'h2310, '0);
    sb.push_back({1'b1, line_of(16'h2310)});
    sb.push_back({1'b0, line_of(16'h1310)});
    repeat (2) @(negedge clk);
    n_checks++;
    if (o_address !== 16'h2310) $display("FAIL rr1_dmem_second: address got %h expected 2310", o_address);
    else n_pass++;
    next_resp("rr1_dmem");
    n_checks++;
    if (got !== want || rd !== wrd) $display("FAIL rr1_dmem: got resp=%b rdata=%h expected resp=%b rdata=%h", got, rd, want, wrd);
    else n_pass++;
    tick();
    dmem_stb = 1'b0; dmem_cyc = 1'b0;
    next_resp("rr1_handoff_imem");
    n_checks++;
    if (got !== want || rd !== wrd) $display("FAIL rr1_handoff_imem: got resp=%b rdata=%h expected resp=%b rdata=%h", got, rd, want, wrd);
    else n_pass++;
    tick();
    idle_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    mem_manual = 1'b1;
    force_resp = 1'b0;
    tick();
    drive_dmem(1'b0, 16'h0000, 16'h2400, '0);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({o_stb, o_cyc, o_address} !== {2'b11, 16'h2400}) $display("FAIL abort_granted: got %h expected %h", {o_stb, o_cyc, o_address}, {2'b11, 16'h2400});
    else n_pass++;
    tick();
    dmem_cyc = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_stb, o_cyc, o_dmem_resp} !== 3'b000) $display("FAIL abort_cyc_low: stb,cyc,resp got %b expected 000", {o_stb, o_cyc, o_dmem_resp});
    else n_pass++;
    tick();
    dmem_stb = 1'b0;
    force_resp = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({pmem_resp, o_imem_resp, o_dmem_resp, o_busy} !== 4'b1000) $display("FAIL abort_stray_resp: pmem_resp,i,d,busy got %b expected 1000", {pmem_resp, o_imem_resp, o_dmem_resp, o_busy});
    else n_pass++;
    tick();
    force_resp = 1'b0;
    mem_manual = 1'b0;
    repeat (2) @(negedge clk);
    // Last completion was imem, so the next conflict must go to dmem.
    tick();
    drive_imem(16'h1400);
    drive_dmem(1'b0, 16'h0000, 16'h2410, '0);
    sb.push_back({1'b1, line_of(16'h2410)});
    sb.push_back({1'b0, line_of(16'h1400)});
    repeat (2) @(negedge clk);
    n_checks++;
    if (o_address !== 16'h2410) $display("FAIL abort_last_grant_kept: address got %h expected 2410", o_address);
    else n_pass++;
    next_resp("abort_then_dmem");
    n_checks++;
    if (got !== want || rd !== wrd) $display("FAIL abort_then_dmem: got resp=%b rdata=%h expected resp=%b rdata=%h", got, rd, want, wrd);
    else n_pass++;
    tick();
    dmem_stb = 1'b0; dmem_cyc = 1'b0;
    next_resp("abort_then_imem");
    n_checks++;
    if (got !== want || rd !== wrd) $display("FAIL abort_then_imem: got resp=%b rdata=%h expected resp=%b rdata=%h", got, rd, want, wrd);
    else n_pass++;
    tick();
    idle_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mem_manual = 1'b1;
    force_resp = 1'b0;
    tick();
    drive_dmem(1'b1, 16'hFFFF, 16'h2500, W_LINE);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({o_busy, o_stb} !== 2'b11) $display("FAIL midreset_granted: busy,stb got %b expected 11", {o_busy, o_stb});
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({o_stb, o_cyc, o_write, o_be, o_address, o_wdata, o_busy, o_dmem_resp} !== '0)
      $display("FAIL midreset_async_outputs: got %h expected 0", {o_stb, o_cyc, o_write, o_be, o_address, o_wdata, o_busy, o_dmem_resp});
    else n_pass++;
    idle_all();
    mem_manual = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL midreset_idle: busy got %b expected 0", o_busy);
    else n_pass++;
    tick();
    drive_imem(16'h1500);
    sb.push_back({1'b0, line_of(16'h1500)});
    next_resp("midreset_resume");
    n_checks++;
    if (got !== want || rd !== wrd) $display("FAIL midreset_resume: got resp=%b rdata=%h expected resp=%b rdata=%h", got, rd, want, wrd);
    else n_pass++;
    tick();
    idle_all();
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0 || o_busy !== 1'b0) $display("FAIL final_drained: queue=%0d busy=%b expected queue=0 busy=0", sb.size(), o_busy);
    else n_pass++;
  endtask

  initial begin
    sel = 0;
    imem_address = '0;
    dmem_address = '0;
    dmem_wdata   = '0;
    test_reset();
    test_imem_read();
    test_dmem_write();
    test_rr0_conflict();
    test_mask();
    do_reset(1);
    test_rr1_conflict();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical memory port between the fetch-stage instruction requester (imem, read-only) and the memory-stage data requester (dmem, read/write).
- Both requester ports and the memory port use the same stb/cyc/write/byte-enable/ack handshake and the same 128-bit line width.
- Grants the port to one requester per transaction. Routes the request to memory and routes the response back to the granted requester.

Parameters:
- RR_MODE, 0, conflict policy: 0 = dmem always wins, 1 = round-robin on simultaneous requests.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- imem_stb  in  1  imem request strobe
- imem_cyc  in  1  imem bus cycle
- imem_address  in  16  imem address (lc3b_word)
- imem_rdata  out  128  read line to imem (lc3b_data)
- imem_resp  out  1  imem acknowledge
- dmem_stb  in  1  dmem request strobe
- dmem_cyc  in  1  dmem bus cycle
- dmem_write  in  1  dmem write enable
- dmem_byte_enable  in  16  dmem byte mask (lc3b_mem_wmask)
- dmem_address  in  16  dmem address
- dmem_wdata  in  128  dmem write line
- dmem_rdata  out  128  read line to dmem
- dmem_resp  out  1  dmem acknowledge
- pmem_stb  out  1  memory strobe
- pmem_cyc  out  1  memory cycle
- pmem_write  out  1  memory write enable
- pmem_byte_enable  out  16  memory byte mask
- pmem_address  out  16  memory address
- pmem_wdata  out  128  memory write line
- pmem_rdata  in  128  memory read line
- pmem_resp  in  1  memory acknowledge
- arb_busy  out  1  high while any grant is held

Behaviour:
- Request rule: a requester is valid when stb & cyc are both high. It holds all fields stable until its resp.
- States: IDLE, GRANT_I, GRANT_D. State is registered. reset forces IDLE from any state, including mid-transaction.
- Reset values:
  - all pmem_* outputs are 0;
  - imem_resp and dmem_resp are 0;
  - arb_busy is 0;
  - last_grant is DMEM, so the first RR conflict goes to imem.
- IDLE:
  - only dmem valid -> GRANT_D;
  - only imem valid -> GRANT_I;
  - both valid: RR_MODE=0 -> GRANT_D; RR_MODE=1 -> the requester not equal to last_grant.
  - pmem_stb and pmem_cyc stay 0 while in IDLE.
- GRANT_x:
  - pmem_* is driven combinationally from requester x.
  - For imem: pmem_write = 0 and pmem_byte_enable = 0, so imem never writes.
  - pmem_rdata is fanned out to both rdata outputs.
  - x_resp = pmem_resp, combinational. The other requester's resp is 0.
- Completion: pmem_resp high in GRANT_x.
  - Update last_grant to x.
  - Set mask_x for exactly one cycle, because the requester drops stb only in the cycle after resp.
  - Next state is GRANT_other if the other requester is valid, otherwise IDLE. This is a back-to-back handoff with no idle bubble.
  - A masked requester is not valid for the arbitration in the next cycle.
- Abort: the granted requester drops cyc before resp.
  - Deassert pmem_cyc and pmem_stb the same cycle.
  - Next state is IDLE. last_grant is unchanged.
- A stray pmem_resp in IDLE is ignored. No resp is forwarded to either requester.
- Latency: request to pmem_stb is 1 cycle from IDLE. pmem_resp to requester resp is 0 cycles.
- No preemption: a new dmem request waits until the imem transaction completes.
- arb_busy = (state != IDLE).

Decomposition:
- lc3b_types supplies lc3b_word, lc3b_data and lc3b_mem_wmask.
- Add to lc3b_types: the enum lc3b_arb_state {IDLE, GRANT_I, GRANT_D} and the enum lc3b_arb_req {IMEM, DMEM}.
- One sub-module, arb_pick: a combinational grant decision from the two valid bits, last_grant and RR_MODE.
- Output muxing stays in mem_arbiter.

Test Plan:
- imem read only, address 0x1000, memory acks after 3 cycles with line L:
  - pmem_stb rises 1 cycle after the request;
  - pmem_write = 0;
  - imem_resp pulses with imem_rdata = L;
  - dmem_resp stays 0;
  - state is IDLE afterwards.
- dmem write, address 0x2008, byte_enable 0x0300, wdata W:
  - pmem fields match exactly;
  - one dmem_resp pulse;
  - imem_resp stays 0.
- Both request in the same cycle:
  - RR_MODE=0 -> dmem first, then imem handed off on the cycle after the dmem resp with no IDLE;
  - RR_MODE=1 from reset -> imem first, and on the next conflict dmem first.
- Requester holds stb one cycle after resp, while the other is idle:
  - no regrant, because of the mask;
  - a fresh request after the mask cycle is granted.
- dmem drops cyc 1 cycle into a grant:
  - pmem_cyc = 0 that cycle;
  - a later pmem_resp is not forwarded to either requester;
  - last_grant is unchanged.
- reset asserted mid-GRANT_D:
  - outputs are 0 immediately, asynchronously;
  - IDLE after reset is released;
  - normal operation resumes.
